proj_ctrl: RTL and testbench

Single-clock run sequencer for a bank of `L` FIFO test lanes. It resets the lanes and holds them in reset while idle. It then releases them for a fixed run window and a drain window, watching every lane's error counter each cycle. At the end it reports a per-lane fail mask and an overall pass flag. It sits at the top of the project, beside the lane instances; the lanes' checker clock is `clk`, or their `errcntr` outputs are already synchronized to `clk`.

---
 rtl/proj_ctrl.sv | 163 ++++++++++++++++
 tb/tb_proj_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/proj_ctrl.sv
// proj_ctrl: run sequencer for a bank of L FIFO test lanes.
//
// Holds the lanes in reset while idle. On start it resets them for RSTCYC
// cycles, releases them for a RUNCYC run window and a DRAINCYC drain window
// while folding every lane's error counter into sticky flags, then reports
// a per-lane fail mask and an overall pass flag.
//
// Ports:
//   clk      in   clock (also the lanes' checker clock)
//   rst      in   synchronous active-high reset
//   start    in   begin a run (sampled only in IDLE)
//   stop     in   end looping (only with PROJ_CTRL_LOOP_EN)
//   errcntr  in   L*EW lane error counters, lane i at [i*EW +: EW]
//   lanerst  out  reset to all lanes
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse when a run completes
//   pass     out  ~|failmask, registered
//   failmask out  per-lane fail flags, updated in CHECK
//   runcnt   out  completed runs, wraps at 255
//
// Build option: define PROJ_CTRL_LOOP_EN to loop DONE -> RST until stop is
// seen in a DONE cycle; sticky flags then accumulate across iterations.

module proj_ctrl #(
    parameter int unsigned L        = 2,
    parameter int unsigned EW       = 8,
    parameter int unsigned TW       = 16,
    parameter int unsigned RSTCYC   = 4,
    parameter int unsigned RUNCYC   = 256,
    parameter int unsigned DRAINCYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [L*EW-1:0] errcntr,
    output logic            lanerst,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [L-1:0]    failmask,
    output logic [7:0]      runcnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [TW-1:0] RST_LOAD   = TW'(RSTCYC - 1);
    localparam logic [TW-1:0] RUN_LOAD   = TW'(RUNCYC - 1);
    localparam logic [TW-1:0] DRAIN_LOAD = TW'(DRAINCYC - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [L-1:0]  sticky_q, sticky_d;
    logic [L-1:0]  failmask_q, failmask_d;
    logic          pass_q, pass_d;
    logic [7:0]    runcnt_q, runcnt_d;
    logic [L-1:0]  lane_nz;

    always_comb begin
        lane_nz = '0;
        for (int unsigned i = 0; i < L; i++) begin
            lane_nz[i] = |errcntr[i*EW +: EW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            sticky_q   <= '0;
            failmask_q <= '0;
            pass_q     <= 1'b1;
            runcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sticky_q   <= sticky_d;
            failmask_q <= failmask_d;
            pass_q     <= pass_d;
            runcnt_q   <= runcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        sticky_d   = sticky_q;
        failmask_d = failmask_q;
        pass_d     = pass_q;
        runcnt_d   = runcnt_q;
        lanerst    = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d  = S_RST;
                    timer_d  = RST_LOAD;
                    sticky_d = '0;
                end
            end
            S_RST: begin
                if (timer_q == '0) begin
                    state_d = S_RUN;
                    timer_d = RUN_LOAD;
                end
            end
            S_RUN: begin
                lanerst  = 1'b0;
                sticky_d = sticky_q | lane_nz;
                if (timer_q == '0) begin
                    state_d = S_DRAIN;
                    timer_d = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                lanerst  = 1'b0;
                sticky_d = sticky_q | lane_nz;
                if (timer_q == '0) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Live counters are folded in here too, so an error landing
                // in the last drain cycle's counter output is not lost.
                failmask_d = sticky_q | lane_nz;
                pass_d     = ~|(sticky_q | lane_nz);
                state_d    = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                runcnt_d = runcnt_q + 8'd1;
`ifdef PROJ_CTRL_LOOP_EN
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RST;
                    timer_d = RST_LOAD;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pass     = pass_q;
    assign failmask = failmask_q;
    assign runcnt   = runcnt_q;

endmodule

// File: tb/tb_proj_ctrl.sv
// Directed bench for proj_ctrl with L=2, EW=8, RSTCYC=4, RUNCYC=16,
// DRAINCYC=4. Cycle 0 is the IDLE cycle in which start is sampled.
module tb_proj_ctrl;

    localparam int L        = 2;
    localparam int EW       = 8;
    localparam int RSTCYC   = 4;
    localparam int RUNCYC   = 16;
    localparam int DRAINCYC = 4;
    localparam int C_CHK    = 1 + RSTCYC + RUNCYC + DRAINCYC;  // 25
    localparam int C_DONE   = C_CHK + 1;                        // 26

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            stop;
    logic [L*EW-1:0] errcntr;
    logic            lanerst;
    logic            busy;
    logic            done;
    logic            pass;
    logic [L-1:0]    failmask;
    logic [7:0]      runcnt;

    int checks = 0;
    int errors = 0;

    proj_ctrl #(
        .L        (L),
        .EW       (EW),
        .TW       (16),
        .RSTCYC   (RSTCYC),
        .RUNCYC   (RUNCYC),
        .DRAINCYC (DRAINCYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .errcntr  (errcntr),
        .lanerst  (lanerst),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .failmask (failmask),
        .runcnt   (runcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          s;           // first cycle errcntr is driven
        int          e;           // last cycle errcntr is driven
        logic [15:0] val;
        bit          hold_start;  // keep start high through DONE
        logic [1:0]  fm;          // expected failmask at DONE
        logic        ps;          // expected pass at DONE
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v, input int runs_exp);
        logic exp_busy, exp_lr, exp_done;
        for (int c = 0; c <= C_DONE + 1; c++) begin
            errcntr = (c >= v.s && c <= v.e) ? v.val : '0;
            start   = (c == 0) || (v.hold_start && c <= C_DONE);
            #4;
            exp_busy = (c >= 1 && c <= C_DONE);
            exp_lr   = !(c >= RSTCYC + 1 && c <= C_CHK - 1);
            exp_done = (c == C_DONE);
            check($sformatf("v%0d c%0d busy/lanerst/done", idx, c),
                  {29'd0, busy, lanerst, done}, {29'd0, exp_busy, exp_lr, exp_done});
            if (c == C_DONE) begin
                check($sformatf("v%0d failmask", idx), {30'd0, failmask}, {30'd0, v.fm});
                check($sformatf("v%0d pass", idx), {31'd0, pass}, {31'd0, v.ps});
            end
            if (c == C_DONE + 1) begin
                check($sformatf("v%0d runcnt", idx), {24'd0, runcnt}, runs_exp);
            end
            next_cycle();
        end
        start   = 1'b0;
        errcntr = '0;
    endtask

    initial begin
        bit saw_done;

        //            s   e   val       hold  fm     ps
        vecs[0] = '{  1,  0, 16'h0000, 1'b0, 2'b00, 1'b1};  // clean
        vecs[1] = '{ 10, 10, 16'h0300, 1'b1, 2'b10, 1'b0};  // lane1 error, start held
        vecs[2] = '{  8,  8, 16'h0001, 1'b0, 2'b01, 1'b0};  // counter back to 0 next cycle
        vecs[3] = '{  1,  4, 16'h0505, 1'b0, 2'b00, 1'b1};  // noise during RST only
        vecs[4] = '{ 26, 26, 16'h0101, 1'b0, 2'b00, 1'b1};  // DONE cycle ignored
        vecs[5] = '{ 25, 25, 16'h0200, 1'b0, 2'b10, 1'b0};  // CHECK cycle counted
        vecs[6] = '{  5,  5, 16'h0100, 1'b0, 2'b10, 1'b0};  // first RUN cycle
        vecs[7] = '{  0,  0, 16'h0303, 1'b0, 2'b00, 1'b1};  // IDLE start cycle ignored
        vecs[8] = '{ 24, 24, 16'h0001, 1'b0, 2'b01, 1'b0};  // last DRAIN cycle

        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b1;
        errcntr = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #4;
        check("reset lanerst", {31'd0, lanerst}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset pass", {31'd0, pass}, 32'd1);
        check("reset failmask", {30'd0, failmask}, 32'd0);
        check("reset runcnt", {24'd0, runcnt}, 32'd0);
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i], i + 1);
        end

        // start held high re-triggers at the first IDLE cycle
        start = 1'b1;
        for (int c = 0; c <= C_DONE + 2; c++) begin
            #4;
            if (c == C_DONE + 1) begin
                check("retrig idle busy", {31'd0, busy}, 32'd0);
                check("retrig runcnt", {24'd0, runcnt}, 32'd10);
            end
            if (c == C_DONE + 2) begin
                check("retrig rst busy", {31'd0, busy}, 32'd1);
                check("retrig rst lanerst", {31'd0, lanerst}, 32'd1);
            end
            next_cycle();
        end
        start = 1'b0;
        rst   = 1'b1;
        next_cycle();
        rst = 1'b0;

        // reset in the middle of RUN
        for (int c = 0; c <= 12; c++) begin
            start   = (c == 0);
            errcntr = (c == 8) ? 16'h0700 : '0;
            rst     = (c == 12);
            #4;
            if (c == 12) begin
                check("midrun lanerst before rst", {31'd0, lanerst}, 32'd0);
            end
            next_cycle();
        end
        rst     = 1'b0;
        errcntr = '0;
        #4;
        check("midrun lanerst", {31'd0, lanerst}, 32'd1);
        check("midrun busy", {31'd0, busy}, 32'd0);
        check("midrun failmask", {30'd0, failmask}, 32'd0);
        check("midrun pass", {31'd0, pass}, 32'd1);
        check("midrun runcnt", {24'd0, runcnt}, 32'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) saw_done = 1'b1;
            next_cycle();
            #4;
        end
        check("midrun no done", {31'd0, saw_done}, 32'd0);
        check("midrun still idle", {31'd0, busy}, 32'd0);
        next_cycle();

`ifdef PROJ_CTRL_LOOP_EN
        // two looped iterations, error only in the first, stop in the second DONE
        for (int c = 0; c <= 2 * C_DONE + 1; c++) begin
            start   = (c == 0);
            stop    = (c == 2 * C_DONE);
            errcntr = (c == 10) ? 16'h0009 : '0;
            #4;
            check($sformatf("loop c%0d busy/done", c), {30'd0, busy, done},
                  {30'd0, (c >= 1 && c <= 2 * C_DONE), (c == C_DONE || c == 2 * C_DONE)});
            if (c == 2 * C_DONE) begin
                check("loop failmask", {30'd0, failmask}, 32'd1);
                check("loop pass", {31'd0, pass}, 32'd0);
            end
            if (c == 2 * C_DONE + 1) begin
                check("loop runcnt", {24'd0, runcnt}, 32'd2);
            end
            next_cycle();
        end
        stop    = 1'b1;
        errcntr = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
